lmac_reg_responder: RTL and testbench
=====================================

// Module: lmac_reg_responder
// PURPOSE
//  LMAC-side responder for the host register read bus, plus a simple write port.
//  Latches host_addr on a reg_rd_start pulse and decodes it against a register map:
//  RW config registers, read-only status inputs and one read-to-clear event counter.
//  Returns mac_regdout together with a one-cycle reg_rd_done_out pulse after a fixed latency.
//  Sits inside the LMAC core, facing the host register-interface initiator.
// PARAMETERS
//  NUM_RW   8             number of RW config registers, byte offsets 0x0000+4*i
//  NUM_RO   4             number of RO status words, byte offsets 0x0100+4*j
//  RD_LAT   3             cycles from reg_rd_start to reg_rd_done_out; legal range 2..15
//  ERR_DATA 32'hBAD0_ADD4 data returned for an unmapped or unaligned read
// PORTS
//  reg_clk         in  1         register clock; the only clock
//  reset           in  1         synchronous, active-high reset
//  host_addr       in  16        byte address of the register
//  reg_rd_start    in  1         one-cycle read request pulse
//  reg_wr_start    in  1         one-cycle write request pulse
//  mac_regdin      in  32        write data, sampled with reg_wr_start
//  mac_regdout     out 32        read data, valid with reg_rd_done_out
//  reg_rd_done_out out 1         one-cycle pulse: mac_regdout is valid
//  addr_err        out 1         one-cycle pulse, coincident with done, on a bad read address
//  busy            out 1         high while a read is in flight (any state except IDLE)
//  cfg_regs        out 32*NUM_RW RW register contents, flattened, reg i at [32*i+:32]
//  stat_in         in  32*NUM_RO live status words, flattened
//  evt_pulse       in  1         increments the read-to-clear counter (offset 0x0200)
// BEHAVIOUR
//  Reset values:
//   - mac_regdout=0, reg_rd_done_out=0, addr_err=0, busy=0
//   - cfg_regs all 0; event counter 0; state RSP_IDLE
//  Reset mid-read: return to IDLE; no done pulse is issued.
//  FSM states (one-hot): RSP_IDLE, RSP_DECODE, RSP_WAIT, RSP_DONE.
//   - IDLE: reg_rd_start=1 -> latch host_addr -> DECODE. This is cycle T0.
//   - DECODE (T1): select the read word into the hold register.
//     -> WAIT if RD_LAT>2; else -> DONE.
//   - WAIT: remain RD_LAT-2 cycles (4-bit counter), then -> DONE.
//   - DONE (T0+RD_LAT): reg_rd_done_out=1 with mac_regdout=hold. Next state is IDLE.
//  mac_regdout holds its value until the next DONE.
//  reg_rd_start while not in IDLE: ignored. No queueing, no error.
//  Read decode:
//   - Bad address: host_addr[1:0]!=0, or offset outside the map. Returns ERR_DATA with addr_err=1.
//   - RO words are sampled in DECODE.
//  Write (any state):
//   - reg_wr_start with a valid RW offset -> cfg_regs[i]<=mac_regdin at that edge.
//   - Writes to RO, counter or invalid offsets are dropped silently.
//   - A write in the same cycle as reg_rd_start to the same register: the read returns the
//     new value, because the read samples in DECODE.
//  Event counter (32-bit):
//   - +1 per evt_pulse; saturates at 32'hFFFF_FFFF.
//   - Cleared in the DECODE cycle of a read to 0x0200, after its value is captured.
//   - evt_pulse in that same DECODE cycle: counter becomes 1, not 0. No event is lost.
// STRUCTURE
//  Package lmac_reg_pkg holds:
//   - RSP_* state encodings
//   - base offsets RW_BASE=16'h0000, RO_BASE=16'h0100, EVT_ADDR=16'h0200
//   - ERR_DATA default
//  Sub-module lmac_rc_counter: saturating 32-bit counter.
//   - inputs inc and clr; clr with inc gives 1
//   - also reused for future statistics registers
// TESTING
//  1. Reset, then read 0x0004:
//     - expect done at T0+3, data 0, addr_err=0
//     - busy high T0+1..T0+3
//  2. Write 0x0008<=32'hCAFE_F00D, then read 0x0008:
//     - expect CAFE_F00D; cfg_regs[95:64] matches
//  3. Read 0x0002 (unaligned) and 0x0300 (unmapped):
//     - each returns BAD0_ADD4 with addr_err=1 coincident with done
//  4. Five evt_pulses, then read 0x0200:
//     - returns 5; a second read returns 0
//     - repeat with evt_pulse in the DECODE cycle: second read returns 1
//  5. Second reg_rd_start at T0+1:
//     - ignored; exactly one done pulse
//     - reset asserted at T0+2 of another read: no done pulse, busy=0 next cycle
//  6. RD_LAT=2 build: done at T0+2; stat_in[31:0]=32'h1234_5678 read at 0x0100 returns that value

Source files
------------

// File: rtl/lmac_reg_pkg.sv
// ---------------------------------------------------------------------------
// lmac_reg_pkg
//   Shared definitions for the LMAC host register responder:
//   - one-hot read FSM state encodings
//   - register map base offsets
//   - default data returned on a bad read address
//   - read-decode result struct
// ---------------------------------------------------------------------------
package lmac_reg_pkg;

    // One-hot read FSM states
    typedef enum logic [3:0] {
        RSP_IDLE   = 4'b0001,
        RSP_DECODE = 4'b0010,
        RSP_WAIT   = 4'b0100,
        RSP_DONE   = 4'b1000
    } rsp_state_t;

    // Register map byte offsets
    localparam logic [15:0] RW_BASE  = 16'h0000;
    localparam logic [15:0] RO_BASE  = 16'h0100;
    localparam logic [15:0] EVT_ADDR = 16'h0200;

    // Read data for an unmapped or unaligned address
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hBAD0_ADD4;

    // Result of decoding the latched read address
    typedef struct packed {
        logic [31:0] data;   // selected read word
        logic        err;    // address was unaligned or outside the map
        logic        evt;    // address hits the read-to-clear counter
    } rd_dec_t;

endpackage : lmac_reg_pkg

// File: rtl/lmac_rc_counter.sv
// ---------------------------------------------------------------------------
// lmac_rc_counter
//   Saturating read-to-clear event counter.
//   Ports:
//     reg_clk  in   clock
//     reset    in   synchronous active-high reset (count -> 0)
//     inc      in   count one event (ignored once saturated)
//     clr      in   clear; clr together with inc yields 1 so no event is lost
//     cnt      out  current count
// ---------------------------------------------------------------------------
module lmac_rc_counter #(
    parameter int W = 32
) (
    input  logic         reg_clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge reg_clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            // The captured value was already taken; an event landing on the
            // clear cycle starts the next accumulation.
            cnt <= {{(W-1){1'b0}}, inc};
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule : lmac_rc_counter

// File: rtl/lmac_reg_responder.sv
// ---------------------------------------------------------------------------
// lmac_reg_responder
//   LMAC-side responder for the host register read bus plus a simple write
//   port. A read latches host_addr on reg_rd_start, decodes it against the
//   register map and returns mac_regdout with a one-cycle reg_rd_done_out
//   pulse exactly RD_LAT cycles after the request.
//
//   Register map (byte offsets):
//     0x0000 + 4*i   RW config register i   (i < NUM_RW)
//     0x0100 + 4*j   RO status word j       (j < NUM_RO)
//     0x0200         read-to-clear event counter
//
//   Ports:
//     reg_clk          in   the only clock
//     reset            in   synchronous active-high reset
//     host_addr        in   register byte address (read latch / write decode)
//     reg_rd_start     in   one-cycle read request, accepted only when idle
//     reg_wr_start     in   one-cycle write request, accepted in any state
//     mac_regdin       in   write data, sampled with reg_wr_start
//     mac_regdout      out  read data, valid with reg_rd_done_out, held after
//     reg_rd_done_out  out  one-cycle read completion pulse
//     addr_err         out  one-cycle pulse with done on a bad read address
//     busy             out  high while a read is in flight
//     cfg_regs         out  RW registers, flattened, reg i at [32*i+:32]
//     stat_in          in   live status words, flattened, word j at [32*j+:32]
//     evt_pulse        in   event counter increment
//
//   RD_LAT legal range is 2..15 (the WAIT counter is 4 bits).
// ---------------------------------------------------------------------------
module lmac_reg_responder
    import lmac_reg_pkg::*;
#(
    parameter int          NUM_RW   = 8,
    parameter int          NUM_RO   = 4,
    parameter int          RD_LAT   = 3,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic                  reg_clk,
    input  logic                  reset,
    input  logic [15:0]           host_addr,
    input  logic                  reg_rd_start,
    input  logic                  reg_wr_start,
    input  logic [31:0]           mac_regdin,
    output logic [31:0]           mac_regdout,
    output logic                  reg_rd_done_out,
    output logic                  addr_err,
    output logic                  busy,
    output logic [32*NUM_RW-1:0]  cfg_regs,
    input  logic [32*NUM_RO-1:0]  stat_in,
    input  logic                  evt_pulse
);

    // WAIT lasts RD_LAT-2 cycles; the counter counts down to zero inclusive.
    localparam logic [3:0] WAIT_LOAD = 4'((RD_LAT > 2) ? (RD_LAT - 3) : 0);
    localparam bit         HAS_WAIT  = (RD_LAT > 2);

    rsp_state_t                    state;
    logic [15:0]                   rd_addr;
    logic [31:0]                   hold_data;
    logic                          hold_err;
    logic [3:0]                    wait_cnt;
    logic [NUM_RW-1:0][31:0]       cfg;
    logic [NUM_RO-1:0][31:0]       stat_w;
    logic [31:0]                   evt_cnt;
    logic                          evt_clr;
    rd_dec_t                       dec;

    assign stat_w   = stat_in;
    assign cfg_regs = cfg;

    // ------------------------------------------------------------------
    // Read decode of the latched address. Evaluated every cycle but only
    // consumed in DECODE, so RO words and the counter are sampled there.
    // ------------------------------------------------------------------
    always_comb begin
        dec = '{data: ERR_DATA, err: 1'b1, evt: 1'b0};
        if (rd_addr[1:0] == 2'b00) begin
            for (int i = 0; i < NUM_RW; i++) begin
                if (rd_addr == RW_BASE + 16'(4 * i)) begin
                    dec.data = cfg[i];
                    dec.err  = 1'b0;
                end
            end
            for (int j = 0; j < NUM_RO; j++) begin
                if (rd_addr == RO_BASE + 16'(4 * j)) begin
                    dec.data = stat_w[j];
                    dec.err  = 1'b0;
                end
            end
            if (rd_addr == EVT_ADDR) begin
                dec.data = evt_cnt;
                dec.err  = 1'b0;
                dec.evt  = 1'b1;
            end
        end
    end

    // Clear lands on the same edge that captures the count into the hold path.
    assign evt_clr = (state == RSP_DECODE) && dec.evt;

    lmac_rc_counter #(.W(32)) u_evt_cnt (
        .reg_clk (reg_clk),
        .reset   (reset),
        .inc     (evt_pulse),
        .clr     (evt_clr),
        .cnt     (evt_cnt)
    );

    // ------------------------------------------------------------------
    // Write port: independent of the read FSM. Only RW offsets land;
    // everything else is dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge reg_clk) begin
        if (reset) begin
            cfg <= '0;
        end else if (reg_wr_start) begin
            for (int i = 0; i < NUM_RW; i++) begin
                if (host_addr == RW_BASE + 16'(4 * i)) begin
                    cfg[i] <= mac_regdin;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read FSM with registered outputs. mac_regdout is loaded only on entry
    // to DONE so it keeps the previous read's value while a new read is in
    // flight.
    // ------------------------------------------------------------------
    always_ff @(posedge reg_clk) begin
        if (reset) begin
            state           <= RSP_IDLE;
            rd_addr         <= '0;
            hold_data       <= '0;
            hold_err        <= 1'b0;
            wait_cnt        <= '0;
            mac_regdout     <= '0;
            reg_rd_done_out <= 1'b0;
            addr_err        <= 1'b0;
            busy            <= 1'b0;
        end else begin
            reg_rd_done_out <= 1'b0;
            addr_err        <= 1'b0;
            case (state)
                RSP_IDLE: begin
                    if (reg_rd_start) begin
                        rd_addr <= host_addr;
                        busy    <= 1'b1;
                        state   <= RSP_DECODE;
                    end
                end
                RSP_DECODE: begin
                    hold_data <= dec.data;
                    hold_err  <= dec.err;
                    if (HAS_WAIT) begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= RSP_WAIT;
                    end else begin
                        // RD_LAT==2: skip WAIT, present the decode directly
                        mac_regdout     <= dec.data;
                        addr_err        <= dec.err;
                        reg_rd_done_out <= 1'b1;
                        state           <= RSP_DONE;
                    end
                end
                RSP_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        mac_regdout     <= hold_data;
                        addr_err        <= hold_err;
                        reg_rd_done_out <= 1'b1;
                        state           <= RSP_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RSP_DONE: begin
                    busy  <= 1'b0;
                    state <= RSP_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= RSP_IDLE;
                end
            endcase
        end
    end

endmodule : lmac_reg_responder

// File: tb/tb_lmac_reg_responder.sv
module tb_lmac_reg_responder;

    localparam int NUM_RW = 8;
    localparam int NUM_RO = 4;
    localparam logic [31:0] ERR = 32'hBAD0_ADD4;

    logic                 reg_clk = 1'b0;
    logic                 reset;
    logic [15:0]          host_addr;
    logic                 reg_rd_start, reg_wr_start, evt_pulse;
    logic [31:0]          mac_regdin;
    logic [32*NUM_RO-1:0] stat_in;

    logic [31:0]          mac_regdout, mac_regdout2;
    logic                 reg_rd_done_out, reg_rd_done_out2;
    logic                 addr_err, addr_err2, busy, busy2;
    logic [32*NUM_RW-1:0] cfg_regs, cfg_regs2;

    always #5 reg_clk = ~reg_clk;

    lmac_reg_responder #(.NUM_RW(NUM_RW), .NUM_RO(NUM_RO), .RD_LAT(3)) dut (
        .reg_clk(reg_clk), .reset(reset), .host_addr(host_addr),
        .reg_rd_start(reg_rd_start), .reg_wr_start(reg_wr_start),
        .mac_regdin(mac_regdin), .mac_regdout(mac_regdout),
        .reg_rd_done_out(reg_rd_done_out), .addr_err(addr_err), .busy(busy),
        .cfg_regs(cfg_regs), .stat_in(stat_in), .evt_pulse(evt_pulse)
    );

    lmac_reg_responder #(.NUM_RW(NUM_RW), .NUM_RO(NUM_RO), .RD_LAT(2)) dut2 (
        .reg_clk(reg_clk), .reset(reset), .host_addr(host_addr),
        .reg_rd_start(reg_rd_start), .reg_wr_start(reg_wr_start),
        .mac_regdin(mac_regdin), .mac_regdout(mac_regdout2),
        .reg_rd_done_out(reg_rd_done_out2), .addr_err(addr_err2), .busy(busy2),
        .cfg_regs(cfg_regs2), .stat_in(stat_in), .evt_pulse(evt_pulse)
    );

    int passed = 0;
    int total  = 0;

    // Reference model state
    logic [31:0] cfg_m [NUM_RW];
    logic [31:0] evt_m;
    logic [31:0] exp_d;
    logic        exp_e;

    // Captured read results
    logic [31:0] r_d, r2_d;
    logic        r_e, r2_e;
    int          r_lat, r2_lat, r_ndone, r2_ndone;
    logic [7:0]  r_busy;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_write(input logic [15:0] a, input logic [31:0] d);
        if (a % 4 == 0 && a < 4 * NUM_RW) cfg_m[a / 4] = d;
    endtask

    task automatic model_read(input logic [15:0] a, input bit evt_dec);
        exp_d = ERR;
        exp_e = 1'b1;
        if (a % 4 != 0) begin
            // unaligned
        end else if (a < 4 * NUM_RW) begin
            exp_d = cfg_m[a / 4]; exp_e = 1'b0;
        end else if (a >= 16'h0100 && a < 16'h0100 + 4 * NUM_RO) begin
            exp_d = stat_in[32 * ((a - 16'h0100) / 4) +: 32]; exp_e = 1'b0;
        end else if (a == 16'h0200) begin
            exp_d = evt_m; exp_e = 1'b0;
            evt_m = 32'd0;
        end
        if (evt_dec) evt_m = sat_inc(evt_m);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_RW; i++) cfg_m[i] = 32'd0;
        evt_m = 32'd0;
    endtask

    task automatic do_reset();
        @(posedge reg_clk); #1;
        reset = 1'b1;
        repeat (3) @(posedge reg_clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        @(posedge reg_clk); #1;
        host_addr = a; mac_regdin = d; reg_wr_start = 1'b1;
        model_write(a, d);
        @(posedge reg_clk); #1;
        reg_wr_start = 1'b0;
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge reg_clk); #1 evt_pulse = 1'b1;
            evt_m = sat_inc(evt_m);
            @(posedge reg_clk); #1 evt_pulse = 1'b0;
        end
    endtask

    // Issue one read at T0 and observe T1..T7 on both instances.
    task automatic rd(input logic [15:0] a, input bit evt_dec, input bit restart,
                      input bit wr_same, input logic [31:0] wd);
        @(posedge reg_clk); #1;
        host_addr = a; reg_rd_start = 1'b1;
        if (wr_same) begin
            mac_regdin = wd; reg_wr_start = 1'b1;
            model_write(a, wd);
        end
        model_read(a, evt_dec);
        r_lat = 0; r2_lat = 0; r_ndone = 0; r2_ndone = 0; r_busy = '0;
        r_d = 'x; r_e = 'x; r2_d = 'x; r2_e = 'x;
        @(posedge reg_clk); #1;
        reg_rd_start = 1'b0; reg_wr_start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            evt_pulse = (k == 1) && evt_dec;
            if (k == 1 && restart) begin
                host_addr = a ^ 16'h0004; reg_rd_start = 1'b1;
            end else begin
                reg_rd_start = 1'b0;
            end
            r_busy[k] = busy;
            if (reg_rd_done_out === 1'b1) begin
                r_ndone++;
                if (r_lat == 0) begin r_lat = k; r_d = mac_regdout; r_e = addr_err; end
            end
            if (reg_rd_done_out2 === 1'b1) begin
                r2_ndone++;
                if (r2_lat == 0) begin r2_lat = k; r2_d = mac_regdout2; r2_e = addr_err2; end
            end
            @(posedge reg_clk); #1;
        end
        evt_pulse = 1'b0; reg_rd_start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (mac_regdout !== 32'd0) $display("FAIL reset_dout: got %h want 0", mac_regdout); else passed++;
        total++; if (reg_rd_done_out !== 1'b0) $display("FAIL reset_done: got %b want 0", reg_rd_done_out); else passed++;
        total++; if (addr_err !== 1'b0) $display("FAIL reset_err: got %b want 0", addr_err); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (cfg_regs !== '0) $display("FAIL reset_cfg: got %h want 0", cfg_regs); else passed++;
        rd(16'h0004, 0, 0, 0, 0);
        total++; if (r_lat !== 3) $display("FAIL t1_latency: got %0d want 3", r_lat); else passed++;
        total++; if (r_d !== 32'd0) $display("FAIL t1_data: got %h want 0", r_d); else passed++;
        total++; if (r_e !== 1'b0) $display("FAIL t1_err: got %b want 0", r_e); else passed++;
        total++; if (r_busy[4:1] !== 4'b0111) $display("FAIL t1_busy: got %b want 0111", r_busy[4:1]); else passed++;
        total++; if (r_ndone !== 1) $display("FAIL t1_ndone: got %0d want 1", r_ndone); else passed++;
    endtask

    task automatic test_write_read();
        wr(16'h0008, 32'hCAFE_F00D);
        rd(16'h0008, 0, 0, 0, 0);
        total++; if (r_d !== 32'hCAFE_F00D) $display("FAIL wr_rd_data: got %h want cafef00d", r_d); else passed++;
        total++; if (cfg_regs[95:64] !== 32'hCAFE_F00D) $display("FAIL wr_cfg: got %h want cafef00d", cfg_regs[95:64]); else passed++;
        // dropped writes: RO, counter, unaligned, out of range
        wr(16'h0100, 32'h1111_1111);
        wr(16'h0200, 32'h2222_2222);
        wr(16'h000A, 32'h3333_3333);
        wr(16'h0020, 32'h4444_4444);
        total++; if (cfg_regs !== {cfg_m[7], cfg_m[6], cfg_m[5], cfg_m[4], cfg_m[3], cfg_m[2], cfg_m[1], cfg_m[0]})
            $display("FAIL wr_dropped: got %h", cfg_regs); else passed++;
        // write and read in the same cycle: read sees new value
        rd(16'h001C, 0, 0, 1, 32'h5A5A_0F0F);
        total++; if (r_d !== 32'h5A5A_0F0F) $display("FAIL wr_same_cycle: got %h want 5a5a0f0f", r_d); else passed++;
    endtask

    task automatic test_bad_addr();
        logic [15:0] bad [5];
        bad[0] = 16'h0002; bad[1] = 16'h0300; bad[2] = 16'h0020;
        bad[3] = 16'h0110; bad[4] = 16'h0201;
        for (int i = 0; i < 5; i++) begin
            rd(bad[i], 0, 0, 0, 0);
            total++; if (r_d !== ERR || r_e !== 1'b1 || r_lat !== 3)
                $display("FAIL bad_addr_%h: got d=%h e=%b lat=%0d want d=%h e=1 lat=3", bad[i], r_d, r_e, r_lat, ERR);
            else passed++;
        end
    endtask

    task automatic test_evt_counter();
        pulse(5);
        rd(16'h0200, 0, 0, 0, 0);
        total++; if (r_d !== 32'd5) $display("FAIL evt_first: got %0d want 5", r_d); else passed++;
        rd(16'h0200, 0, 0, 0, 0);
        total++; if (r_d !== 32'd0) $display("FAIL evt_cleared: got %0d want 0", r_d); else passed++;
        pulse(3);
        rd(16'h0200, 1, 0, 0, 0);
        total++; if (r_d !== 32'd3) $display("FAIL evt_dec_pulse: got %0d want 3", r_d); else passed++;
        rd(16'h0200, 0, 0, 0, 0);
        total++; if (r_d !== 32'd1) $display("FAIL evt_not_lost: got %0d want 1", r_d); else passed++;
    endtask

    task automatic test_back_to_back();
        wr(16'h0010, 32'hABCD_0010);
        wr(16'h0014, 32'hABCD_0014);
        rd(16'h0010, 0, 1, 0, 0);
        total++; if (r_ndone !== 1) $display("FAIL restart_ndone: got %0d want 1", r_ndone); else passed++;
        total++; if (r_d !== 32'hABCD_0010) $display("FAIL restart_data: got %h want abcd0010", r_d); else passed++;
    endtask

    task automatic test_reset_mid_read();
        int nd;
        nd = 0;
        @(posedge reg_clk); #1;
        host_addr = 16'h0004; reg_rd_start = 1'b1;
        @(posedge reg_clk); #1;           // T1
        reg_rd_start = 1'b0;
        if (reg_rd_done_out === 1'b1) nd++;
        @(posedge reg_clk); #1;           // T2
        reset = 1'b1;
        if (reg_rd_done_out === 1'b1) nd++;
        @(posedge reg_clk); #1;           // T3
        reset = 1'b0;
        model_reset();
        total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else passed++;
        for (int k = 3; k <= 6; k++) begin
            if (reg_rd_done_out === 1'b1) nd++;
            @(posedge reg_clk); #1;
        end
        total++; if (nd !== 0) $display("FAIL rst_mid_done: got %0d pulses want 0", nd); else passed++;
    endtask

    task automatic test_lat2();
        stat_in[31:0] = 32'h1234_5678;
        rd(16'h0100, 0, 0, 0, 0);
        total++; if (r2_lat !== 2) $display("FAIL lat2_latency: got %0d want 2", r2_lat); else passed++;
        total++; if (r2_d !== 32'h1234_5678 || r2_e !== 1'b0)
            $display("FAIL lat2_data: got %h e=%b want 12345678 e=0", r2_d, r2_e); else passed++;
        total++; if (r2_ndone !== 1) $display("FAIL lat2_ndone: got %0d want 1", r2_ndone); else passed++;
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] oob [5];
        oob[0] = 16'h0020; oob[1] = 16'h0110; oob[2] = 16'h0204;
        oob[3] = 16'h0300; oob[4] = 16'hFFFC;
        for (int it = 0; it < 40; it++) begin
            bit ed, ws;
            stat_in = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 2) == 0) wr(16'($urandom_range(0, NUM_RW - 1) * 4), $urandom);
            if ($urandom_range(0, 2) == 0) pulse($urandom_range(1, 4));
            case ($urandom_range(0, 4))
                0: a = 16'($urandom_range(0, NUM_RW - 1) * 4);
                1: a = 16'h0100 + 16'($urandom_range(0, NUM_RO - 1) * 4);
                2: a = 16'h0200;
                3: a = 16'($urandom_range(0, 16'h0210)) | 16'h0001;
                default: a = oob[$urandom_range(0, 4)];
            endcase
            ed = ($urandom_range(0, 3) == 0);
            ws = ($urandom_range(0, 4) == 0);
            rd(a, ed, 0, ws, $urandom);
            total++; if (r_d !== exp_d || r_e !== exp_e || r_lat !== 3)
                $display("FAIL rand_%0d a=%h: got d=%h e=%b lat=%0d want d=%h e=%b lat=3", it, a, r_d, r_e, r_lat, exp_d, exp_e);
            else passed++;
            total++; if (r2_d !== exp_d || r2_e !== exp_e || r2_lat !== 2)
                $display("FAIL rand2_%0d a=%h: got d=%h e=%b lat=%0d want d=%h e=%b lat=2", it, a, r2_d, r2_e, r2_lat, exp_d, exp_e);
            else passed++;
        end
    endtask

    initial begin
        reset = 1'b1; host_addr = '0; reg_rd_start = 1'b0; reg_wr_start = 1'b0;
        mac_regdin = '0; evt_pulse = 1'b0; stat_in = '0;
        model_reset();
        test_reset();
        test_write_read();
        test_bad_addr();
        test_evt_counter();
        test_back_to_back();
        test_reset_mid_read();
        test_lat2();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_lmac_reg_responder
